// File: rtl/dac_pkg.sv
// Shared types and constants for the serial DAC model: frame width, control-frame
// opcodes, LDAC modes and the frame-receiver states.
package dac_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 3;

    typedef enum logic [1:0] {
        CTRL_REF,
        CTRL_LDAC,
        CTRL_PD,
        CTRL_RST
    } ctrl_op_t;

    typedef enum logic [1:0] {
        LDAC_TRANSPARENT,
        LDAC_PIN,
        LDAC_ONESHOT
    } ldac_mode_t;

    typedef enum logic [1:0] {
        FR_SHIFT,
        FR_FULL,
        FR_OVER
    } frame_state_t;

    // Encoding 2'b11 of the LDAC-mode field is reserved and leaves the mode alone.
    function automatic logic ldac_mode_valid(input logic [1:0] code);
        return code != 2'b11;
    endfunction

endpackage

// File: rtl/dac_pin_sync.sv
// Two-flop synchroniser for an asynchronous host pin, followed by an edge-detect
// flop; rise/fall are single-cycle pulses aligned with the synchronised level.
module dac_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST_b,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    // Reset to the pin's idle level so releasing reset does not fabricate an edge.
    always_ff @(posedge CLK or negedge RST_b) begin
        if (!RST_b) begin
            sync1_reg <= RST_VAL;
            sync2_reg <= RST_VAL;
            prev_reg  <= RST_VAL;
        end else begin
            sync1_reg <= pin;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign level = sync2_reg;
    assign rise  = sync2_reg & ~prev_reg;
    assign fall  = ~sync2_reg & prev_reg;

endmodule

// File: rtl/dac_serial_model_param.sv
// Oversampling model of an N-channel 16-bit-frame serial DAC: receives frames on
// SCLK/SYNC_b/DIN, decodes data and control words, and drives per-channel codes.
module dac_serial_model_param
    import dac_pkg::*;
#(
    parameter int N_CH = 8,
    parameter int RES  = 10
) (
    input  logic                      CLK,
    input  logic                      RST_b,
    input  logic                      SCLK,
    input  logic                      SYNC_b,
    input  logic                      DIN,
    input  logic                      LDAC_b,
    output logic [N_CH-1:0][RES-1:0]  VOUT,
    output logic [N_CH-1:0]           PD_MASK,
    output logic [1:0]                GAIN,
    output logic [1:0]                BUF,
    output logic [1:0]                VDD_REF,
    output logic                      FRAME_DONE,
    output logic                      FRAME_ERR
);

    logic sclk_fall;
    logic sclk_level_unused;
    logic sclk_rise_unused;
    logic sync_level;
    logic sync_rise;
    logic sync_fall_unused;
    logic ldac_fall;
    logic ldac_level_unused;
    logic ldac_rise_unused;
    logic din_level;
    logic din_rise_unused;
    logic din_fall_unused;

    dac_pin_sync #(.RST_VAL(1'b1)) u_sclk_sync (
        .CLK   (CLK),
        .RST_b (RST_b),
        .pin   (SCLK),
        .level (sclk_level_unused),
        .rise  (sclk_rise_unused),
        .fall  (sclk_fall)
    );

    dac_pin_sync #(.RST_VAL(1'b1)) u_sync_sync (
        .CLK   (CLK),
        .RST_b (RST_b),
        .pin   (SYNC_b),
        .level (sync_level),
        .rise  (sync_rise),
        .fall  (sync_fall_unused)
    );

    dac_pin_sync #(.RST_VAL(1'b1)) u_ldac_sync (
        .CLK   (CLK),
        .RST_b (RST_b),
        .pin   (LDAC_b),
        .level (ldac_level_unused),
        .rise  (ldac_rise_unused),
        .fall  (ldac_fall)
    );

    dac_pin_sync #(.RST_VAL(1'b0)) u_din_sync (
        .CLK   (CLK),
        .RST_b (RST_b),
        .pin   (DIN),
        .level (din_level),
        .rise  (din_rise_unused),
        .fall  (din_fall_unused)
    );

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    frame_state_t           state_reg,   state_next;
    logic [3:0]             bit_cnt_reg, bit_cnt_next;
    logic [FRAME_W-2:0]     shift_reg,   shift_next;
    logic [FRAME_W-1:0]     frame_word;
    logic                   frame_exec;
    logic                   frame_err_next;

    always_ff @(posedge CLK or negedge RST_b) begin
        if (!RST_b) begin
            state_reg   <= FR_SHIFT;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
        end
    end

    // The 16th bit is taken straight from the DIN synchroniser so the frame
    // executes on the same cycle as its last SCLK fall.
    assign frame_word = {shift_reg, din_level};

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        frame_exec     = 1'b0;
        frame_err_next = 1'b0;
        if (sync_rise) begin
            if (state_reg == FR_SHIFT && bit_cnt_reg != '0) begin
                frame_err_next = 1'b1;
            end
            state_next   = FR_SHIFT;
            bit_cnt_next = '0;
        end else if (!sync_level && sclk_fall) begin
            case (state_reg)
                FR_SHIFT: begin
                    if (bit_cnt_reg == 4'd15) begin
                        frame_exec   = 1'b1;
                        state_next   = FR_FULL;
                        bit_cnt_next = '0;
                    end else begin
                        shift_next   = {shift_reg[FRAME_W-3:0], din_level};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
                FR_FULL: begin
                    frame_err_next = 1'b1;
                    state_next     = FR_OVER;
                end
                FR_OVER: begin
                    state_next = FR_OVER;
                end
                default: begin
                    state_next   = FR_SHIFT;
                    bit_cnt_next = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame decode
    // ------------------------------------------------------------------
    ctrl_op_t               frame_op;
    logic [ADDR_W-1:0]      frame_addr;
    logic [RES-1:0]         frame_data;
    logic                   data_wr;
    logic                   ctrl_wr;
    logic                   clr_regs;
    logic                   clr_full;
    logic                   xfer_set;

    ldac_mode_t             mode_reg;
    logic                   xfer_reg;
    logic                   frame_done_reg;
    logic                   frame_err_reg;
    logic [N_CH-1:0]        pd_reg;
    logic [1:0]             gain_reg;
    logic [1:0]             buf_reg;
    logic [1:0]             vdd_ref_reg;

    assign frame_op   = ctrl_op_t'(frame_word[14:13]);
    assign frame_addr = frame_word[14:12];
    assign frame_data = frame_word[11 -: RES];
    assign data_wr    = frame_exec && !frame_word[FRAME_W-1];
    assign ctrl_wr    = frame_exec &&  frame_word[FRAME_W-1];
    assign clr_regs   = ctrl_wr && (frame_op == CTRL_RST);
    assign clr_full   = clr_regs && frame_word[12];

    // A frame completion and an LDAC fall on the same cycle merge into one request.
    assign xfer_set = (data_wr && (mode_reg == LDAC_TRANSPARENT || mode_reg == LDAC_ONESHOT))
                   || (ldac_fall && mode_reg == LDAC_PIN);

    always_ff @(posedge CLK or negedge RST_b) begin
        if (!RST_b) begin
            mode_reg       <= LDAC_TRANSPARENT;
            xfer_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            pd_reg         <= '0;
            gain_reg       <= '0;
            buf_reg        <= '0;
            vdd_ref_reg    <= '0;
        end else begin
            xfer_reg       <= xfer_set;
            frame_done_reg <= frame_exec;
            frame_err_reg  <= frame_err_next;

            if (clr_full) begin
                mode_reg <= LDAC_TRANSPARENT;
            end else if (ctrl_wr && frame_op == CTRL_LDAC && ldac_mode_valid(frame_word[1:0])) begin
                mode_reg <= ldac_mode_t'(frame_word[1:0]);
            end else if (data_wr && mode_reg == LDAC_ONESHOT) begin
                mode_reg <= LDAC_PIN;
            end

            if (clr_full) begin
                pd_reg <= '0;
            end else if (ctrl_wr && frame_op == CTRL_PD) begin
                pd_reg <= frame_word[N_CH-1:0];
            end

            if (clr_full) begin
                gain_reg    <= '0;
                buf_reg     <= '0;
                vdd_ref_reg <= '0;
            end else if (ctrl_wr && frame_op == CTRL_REF) begin
                vdd_ref_reg <= frame_word[1:0];
                buf_reg     <= frame_word[3:2];
                gain_reg    <= frame_word[5:4];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel input and DAC registers
    // ------------------------------------------------------------------
    logic [RES-1:0] input_reg [N_CH];
    logic [RES-1:0] dac_reg   [N_CH];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic wr_en;
            // Addresses at or above N_CH match no channel and are dropped here.
            assign wr_en = data_wr && (frame_addr == ADDR_W'(gi));

            always_ff @(posedge CLK or negedge RST_b) begin
                if (!RST_b) begin
                    input_reg[gi] <= '0;
                    dac_reg[gi]   <= '0;
                end else begin
                    if (clr_regs) begin
                        input_reg[gi] <= '0;
                    end else if (wr_en) begin
                        input_reg[gi] <= frame_data;
                    end
                    if (clr_regs) begin
                        dac_reg[gi] <= '0;
                    end else if (xfer_reg) begin
                        dac_reg[gi] <= input_reg[gi];
                    end
                end
            end

            assign VOUT[gi] = pd_reg[gi] ? '0 : dac_reg[gi];
        end
    endgenerate

    assign PD_MASK    = pd_reg;
    assign GAIN       = gain_reg;
    assign BUF        = buf_reg;
    assign VDD_REF    = vdd_ref_reg;
    assign FRAME_DONE = frame_done_reg;
    assign FRAME_ERR  = frame_err_reg;

endmodule

// File: tb/tb_dac_serial_model_param.sv
// Directed and randomised frames against a behavioural DAC model; a second
// instance at RES=12 shares the pins for the resolution check.
module tb_dac_serial_model_param;

    localparam int N_CH = 8;
    localparam int RES  = 10;

    logic CLK = 1'b0;
    logic RST_b, SCLK, SYNC_b, DIN, LDAC_b;

    logic [N_CH-1:0][RES-1:0] VOUT;
    logic [N_CH-1:0]          PD_MASK;
    logic [1:0]               GAIN, BUF, VDD_REF;
    logic                     FRAME_DONE, FRAME_ERR;

    logic [N_CH-1:0][11:0]    VOUT12;
    logic [N_CH-1:0]          PD_MASK12;
    logic [1:0]               GAIN12, BUF12, VDD_REF12;
    logic                     FRAME_DONE12, FRAME_ERR12;

    dac_serial_model_param #(.N_CH(N_CH), .RES(RES)) dut (
        .CLK(CLK), .RST_b(RST_b), .SCLK(SCLK), .SYNC_b(SYNC_b), .DIN(DIN), .LDAC_b(LDAC_b),
        .VOUT(VOUT), .PD_MASK(PD_MASK), .GAIN(GAIN), .BUF(BUF), .VDD_REF(VDD_REF),
        .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR)
    );

    dac_serial_model_param #(.N_CH(N_CH), .RES(12)) dut12 (
        .CLK(CLK), .RST_b(RST_b), .SCLK(SCLK), .SYNC_b(SYNC_b), .DIN(DIN), .LDAC_b(LDAC_b),
        .VOUT(VOUT12), .PD_MASK(PD_MASK12), .GAIN(GAIN12), .BUF(BUF12), .VDD_REF(VDD_REF12),
        .FRAME_DONE(FRAME_DONE12), .FRAME_ERR(FRAME_ERR12)
    );

    always #5 CLK = ~CLK;

    // Monitor: pulse counts and the cycle on which events were last seen.
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int done_cyc = 0, vout_chg_cyc = 0;
    logic [N_CH-1:0][RES-1:0] vout_prev = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (FRAME_DONE) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (FRAME_ERR) err_cnt <= err_cnt + 1;
        if (FRAME_DONE && FRAME_ERR) both_cnt <= both_cnt + 1;
        if (VOUT != vout_prev) vout_chg_cyc <= cyc;
        vout_prev <= VOUT;
    end

    // Behavioural model
    logic [RES-1:0] in_m  [N_CH];
    logic [RES-1:0] dac_m [N_CH];
    logic [7:0]     pd_m;
    logic [1:0]     gain_m, buf_m, vdd_m;
    int             mode_m;   // 0 transparent, 1 pin, 2 oneshot

    int n_assert = 0;
    int n_fail   = 0;
    int fall16_cyc = 0;
    int ldac_cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            in_m[i]  = '0;
            dac_m[i] = '0;
        end
        pd_m = '0; gain_m = '0; buf_m = '0; vdd_m = '0; mode_m = 0;
    endtask

    task automatic model_transfer();
        for (int i = 0; i < N_CH; i++) dac_m[i] = in_m[i];
    endtask

    task automatic model_frame(input logic [15:0] f);
        int        a;
        logic [11:0] d;
        a = int'(f[14:12]);
        d = f[11:0];
        if (!f[15]) begin
            if (a < N_CH) in_m[a] = RES'(d >> (12 - RES));
            if (mode_m == 0 || mode_m == 2) begin
                model_transfer();
                if (mode_m == 2) mode_m = 1;
            end
        end else begin
            case (f[14:13])
                2'd0: begin vdd_m = f[1:0]; buf_m = f[3:2]; gain_m = f[5:4]; end
                2'd1: if (f[1:0] != 2'd3) mode_m = int'(f[1:0]);
                2'd2: pd_m = f[7:0];
                default: begin
                    for (int i = 0; i < N_CH; i++) begin
                        in_m[i]  = '0;
                        dac_m[i] = '0;
                    end
                    if (f[12]) begin
                        pd_m = '0; gain_m = '0; buf_m = '0; vdd_m = '0; mode_m = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N_CH; i++) begin
            check($sformatf("%s vout%0d", tag, i), 32'(VOUT[i]), 32'(pd_m[i] ? '0 : dac_m[i]));
        end
        check({tag, " pd"},   32'(PD_MASK), 32'(pd_m));
        check({tag, " gain"}, 32'(GAIN),    32'(gain_m));
        check({tag, " buf"},  32'(BUF),     32'(buf_m));
        check({tag, " vdd"},  32'(VDD_REF), 32'(vdd_m));
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Drives nbits MSB-first at 8 CLK per SCLK; optional reset pulse at bit rst_at.
    task automatic send(input logic [16:0] bits, input int nbits, input int rst_at);
        @(negedge CLK);
        SYNC_b = 1'b0;
        clk_n(4);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                RST_b = 1'b0;
                #1;
                model_reset();
                check_all("async_reset");
            end
            SCLK = 1'b1;
            DIN  = bits[nbits-1-i];
            clk_n(4);
            SCLK = 1'b0;
            if (i == 15) fall16_cyc = cyc;
            clk_n(4);
        end
        SCLK = 1'b1;
        clk_n(4);
        SYNC_b = 1'b1;
        clk_n(8);
        if (rst_at >= 0) begin
            RST_b = 1'b1;
            clk_n(4);
        end
    endtask

    task automatic frame(input logic [15:0] f);
        send({1'b0, f}, 16, -1);
        model_frame(f);
    endtask

    task automatic pulse_ldac();
        @(negedge CLK);
        LDAC_b   = 1'b0;
        ldac_cyc = cyc;
        clk_n(4);
        LDAC_b = 1'b1;
        clk_n(6);
        if (mode_m == 1) model_transfer();
    endtask

    initial begin
        int d0, e0, r;
        logic [15:0] f;

        RST_b = 1'b0; SCLK = 1'b1; SYNC_b = 1'b1; DIN = 1'b0; LDAC_b = 1'b1;
        model_reset();
        clk_n(3);
        check_all("reset");
        check("reset frame_done", 32'(FRAME_DONE), 32'd0);
        check("reset frame_err",  32'(FRAME_ERR),  32'd0);
        RST_b = 1'b1;
        clk_n(4);

        // 1: transparent write, exact latency
        d0 = done_cnt;
        frame(16'h2A94);
        check("t1 done_count", 32'(done_cnt - d0), 32'd1);
        check("t1 done_latency", 32'(done_cyc - fall16_cyc), 32'd3);
        check("t1 vout_latency", 32'(vout_chg_cyc - fall16_cyc), 32'd4);
        check("t1 vout2_value", 32'(VOUT[2]), 32'h2A5);
        check_all("t1");

        // 2: PIN mode holds until LDAC_b falls
        frame(16'hA001);
        frame(16'h2555);
        frame(16'h0333);
        check_all("t2 held");
        pulse_ldac();
        check("t2 ldac_latency", 32'(vout_chg_cyc - ldac_cyc), 32'd4);
        check_all("t2 loaded");

        // 3: power-down masks and restores
        frame(16'hC005);
        check_all("t3 pd");
        frame(16'hC000);
        check_all("t3 restore");

        // 4: short and long frames
        d0 = done_cnt; e0 = err_cnt;
        send(17'h00155, 10, -1);
        check("t4 short err", 32'(err_cnt - e0), 32'd1);
        check("t4 short done", 32'(done_cnt - d0), 32'd0);
        check_all("t4 short");
        d0 = done_cnt; e0 = err_cnt;
        send({16'h3ABC, 1'b1}, 17, -1);
        model_frame(16'h3ABC);
        check("t4 long err", 32'(err_cnt - e0), 32'd1);
        check("t4 long done", 32'(done_cnt - d0), 32'd1);
        pulse_ldac();
        check_all("t4 long");

        // 5: ONESHOT then reverts to PIN; full clear
        frame(16'hA002);
        frame(16'h4111);
        check_all("t5 oneshot");
        frame(16'h5222);
        check_all("t5 waits");
        pulse_ldac();
        check_all("t5 ldac");
        frame(16'h8015);
        frame(16'hF000);
        check_all("t5 clear");
        frame(16'h1123);
        check_all("t5 transparent");

        // Randomised mix of data, control frames and LDAC pulses
        for (int n = 0; n < 24; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 9) begin
                pulse_ldac();
                check_all($sformatf("rnd%0d ldac", n));
            end else begin
                if (r <= 5)      f = {1'b0, 15'($urandom)};
                else if (r == 6) f = 16'h8000 | 16'($urandom_range(0, 63));
                else if (r == 7) f = 16'hA000 | 16'($urandom_range(0, 3));
                else             f = 16'hC000 | 16'($urandom_range(0, 255));
                d0 = done_cnt;
                frame(f);
                check($sformatf("rnd%0d f=%h done", n, f), 32'(done_cnt - d0), 32'd1);
                check($sformatf("rnd%0d done_latency", n), 32'(done_cyc - fall16_cyc), 32'd3);
                check_all($sformatf("rnd%0d f=%h", n, f));
            end
        end

        // 6: asynchronous reset mid-frame, then RES=10 and RES=12 decode
        frame(16'hF000);
        frame(16'h7155);
        frame(16'h8015);
        check_all("t6 pre");
        e0 = err_cnt;
        send(17'h01234, 16, 8);
        check("t6 no_err", 32'(err_cnt - e0), 32'd0);
        check_all("t6 after_reset");
        frame(16'h2A95);
        check_all("t6 res10");
        check("t6 res12 vout2", 32'(VOUT12[2]), 32'hA95);
        check("t6 res12 vout0", 32'(VOUT12[0]), 32'h000);
        check("done_err_exclusive", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
